// File: rtl/secded_pkg.sv
// secded_pkg: shared SEC/DED widths, Hamming position map and check-bit function
package secded_pkg;
  localparam int DATA_W = 16;
  localparam int CHK_W  = 6;
  localparam int CODE_W = DATA_W + CHK_W;
  localparam logic [4:0] POS [DATA_W] = '{
    5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };
  // c[i] covers data bits whose Hamming position has bit i set; c[5] is overall parity
  function automatic logic [CHK_W-1:0] secded_chk(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int k = 0; k < DATA_W; k++)
      for (int i = 0; i < CHK_W - 1; i++)
        c[i] = c[i] ^ (d[k] & POS[k][i]);
    c[CHK_W-1] = ^{d, c[CHK_W-2:0]};
    return c;
  endfunction
endpackage

// File: rtl/secded_fifo2.sv
// secded_fifo2: generic 2-entry valid/ready buffer with registered head and flush
module secded_fifo2 #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic         push, pop;
  assign in_ready  = (cnt_q != 2'd2) && !clr;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // next occupancy and entries; a push into an emptying single entry becomes the new head
  always_comb begin
    cnt_d  = clr ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) ? in_data :
             (pop && cnt_q == 2'd2) ? tail_q : head_q;
    tail_d = (push && cnt_q == 2'd1 && !pop) ? in_data : tail_q;
  end
  // state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: rtl/secded_encoder_stream.sv
// secded_encoder_stream: streaming 16->22 SEC/DED encoder; optional SECDED_ERR_INJECT_EN adds one-shot error injection
module secded_encoder_stream
  import secded_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
`ifdef SECDED_ERR_INJECT_EN
  input  logic              inj_arm,
  input  logic [CODE_W-1:0] inj_mask,
`endif
  output logic [CNT_W-1:0]  word_cnt
);
  logic              accept;
  logic [CODE_W-1:0] inj, code;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  assign accept   = in_valid && in_ready;
  assign code     = {secded_chk(in_data), in_data} ^ inj;
  assign word_cnt = word_cnt_q;
`ifdef SECDED_ERR_INJECT_EN
  logic              armed_q, armed_d;
  logic [CODE_W-1:0] mask_q, mask_d;
  // a same-cycle arm wins over a pending mask; any accept consumes the armed state
  always_comb begin
    inj     = inj_arm ? inj_mask : armed_q ? mask_q : '0;
    armed_d = !accept && (inj_arm || armed_q);
    mask_d  = inj_arm ? inj_mask : mask_q;
  end
  // injection state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      armed_q <= armed_d;
      mask_q  <= mask_d;
    end
  end
`else
  assign inj = '0;
`endif
  // saturating count of accepted words
  always_comb word_cnt_d = (accept && word_cnt_q != '1) ? word_cnt_q + CNT_W'(1) : word_cnt_q;
  // counter register
  always_ff @(posedge clk) begin
    if (rst) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end
  secded_fifo2 #(.W(CODE_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_code)
  );
endmodule

// File: tb/tb_secded_encoder_stream.sv
// tb_secded_encoder_stream: directed and table-driven bench for secded_encoder_stream
module tb_secded_encoder_stream;
  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [15:0] in_data = '0, word_cnt;
  logic [21:0] out_code;
  int          total = 0, bad = 0;
`ifdef SECDED_ERR_INJECT_EN
  logic        inj_arm = 1'b0;
  logic [21:0] inj_mask = '0;
`endif

  secded_encoder_stream dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
`ifdef SECDED_ERR_INJECT_EN
    .inj_arm   (inj_arm),
    .inj_mask  (inj_mask),
`endif
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [21:0] code;
  } vec_t;

  // reference encoder built from the position map: data fills non-power-of-two slots
  function automatic logic [21:0] enc(input logic [15:0] d);
    logic [4:0] s;
    int k;
    s = '0;
    k = 0;
    for (int p = 1; p <= 21; p++)
      if ((p & (p - 1)) != 0) begin
        if (d[k]) s = s ^ 5'(p);
        k++;
      end
    return {^d ^ ^s, s, d};
  endfunction

  // checker model: {overall parity, position syndrome}; zero means clean
  function automatic logic [5:0] syn(input logic [21:0] cw);
    logic [4:0] s;
    logic b;
    int k;
    s = '0;
    k = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) == 0) b = cw[16 + $clog2(p)];
      else begin
        b = cw[k];
        k++;
      end
      if (b) s = s ^ 5'(p);
    end
    return {^cw, s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [6];
  logic [15:0] d, cnt0;
  logic [21:0] e;

  initial begin
    tbl[0] = '{16'h0000, 22'h000000};
    tbl[1] = '{16'h0001, 22'h230001};
    tbl[2] = '{16'hFFFF, 22'h1EFFFF};
    tbl[3] = '{16'h0002, 22'h250002};
    tbl[4] = '{16'h8000, 22'h158000};
    tbl[5] = '{16'h0800, 22'h310800};
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_code", 32'(out_code), 0);
    chk("reset word_cnt", 32'(word_cnt), 0);
    chk("reset in_ready", 32'(in_ready), 1);

    // table vectors, one word per cycle with the consumer always ready
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      in_data  = tbl[i].data;
      chk("tbl in_ready", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      chk("tbl out_valid", 32'(out_valid), 1);
      chk($sformatf("tbl code %h", tbl[i].data), 32'(out_code), 32'(tbl[i].code));
      chk("tbl syndrome", 32'(syn(out_code)), 0);
    end
    chk("tbl word_cnt", 32'(word_cnt), 6);
    step();
    chk("tbl drained", 32'(out_valid), 0);

    // backpressure: two accepted, third waits for space
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    step();
    in_data = 16'h2222;
    step();
    in_data = 16'h3333;
    chk("bp full in_ready", 32'(in_ready), 0);
    step();
    chk("bp hold head", 32'(out_code), 32'(enc(16'h1111)));
    chk("bp word_cnt", 32'(word_cnt), 8);
    out_ready = 1'b1;
    step();
    chk("bp drain 1", 32'(out_code), 32'(enc(16'h2222)));
    chk("bp space in_ready", 32'(in_ready), 1);
    chk("bp third not yet", 32'(word_cnt), 8);
    step();
    in_valid = 1'b0;
    chk("bp drain 2", 32'(out_code), 32'(enc(16'h3333)));
    chk("bp third accepted", 32'(word_cnt), 9);
    step();
    chk("bp empty", 32'(out_valid), 0);

    // continuous random stream at full throughput
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom);
      in_valid = 1'b1;
      in_data  = d;
      chk("stream in_ready", 32'(in_ready), 1);
      step();
      chk("stream out_valid", 32'(out_valid), 1);
      chk("stream code", 32'(out_code), 32'(enc(d)));
      chk("stream syndrome", 32'(syn(out_code)), 0);
    end
    in_valid = 1'b0;
    chk("stream word_cnt", 32'(word_cnt), 109);
    step();

    // flush with a full buffer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hA5A5;
    step();
    in_data = 16'h5A5A;
    step();
    cnt0    = word_cnt;
    in_data = 16'hBEEF;
    clr     = 1'b1;
    chk("clr in_ready", 32'(in_ready), 0);
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr out_valid", 32'(out_valid), 0);
    chk("clr word_cnt", 32'(word_cnt), 32'(cnt0));
    out_ready = 1'b1;

    // reset mid-stream with a word presented
    in_valid = 1'b1;
    in_data  = 16'h0F0F;
    step();
    chk("pre-rst out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_code", 32'(out_code), 0);
    chk("rst word_cnt", 32'(word_cnt), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post-rst in_ready", 32'(in_ready), 1);
    chk("post-rst out_valid", 32'(out_valid), 0);

`ifdef SECDED_ERR_INJECT_EN
    // one-shot error injection on data bit 3 (Hamming position 7)
    inj_arm  = 1'b1;
    inj_mask = 22'h000008;
    step();
    inj_arm = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    step();
    e = enc(16'h1234) ^ 22'h000008;
    chk("inj code", 32'(out_code), 32'(e));
    chk("inj single error", 32'(syn(out_code)), 32'h27);
    in_data = 16'h1235;
    step();
    in_valid = 1'b0;
    chk("inj next clean", 32'(out_code), 32'(enc(16'h1235)));
    chk("inj next syndrome", 32'(syn(out_code)), 0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
